// File: rtl/alu_status_unit.sv
// Status stage after the ALU: registered result, NZCV flags, condition evaluation and a flags
// save stack. Optional overflow event counter is enabled by defining ALU_STATUS_OVF_CNT_EN.
module alu_status_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_c,
    input  logic              alu_v,
    input  logic              res_we,
    input  logic              flags_we,
    input  logic              push,
    input  logic              pop,
    input  logic              err_clr,
    input  logic [3:0]        cond,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              cond_pass,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_err,
    output logic [15:0]       ovf_count
);

    localparam int unsigned PtrW = $clog2(STACK_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [3:0]        flags_q, flags_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              stk_err_q, stk_err_d;
    logic [3:0]        stack_q [STACK_DEPTH];

    logic            full, empty, push_ok, pop_ok, err_ev;
    logic [PtrW-1:0] top_idx;
    logic            fn, fz, fc, fv;

    assign full    = (cnt_q == CntW'(STACK_DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push && !pop && !full;
    assign pop_ok  = pop && !push && !empty;
    assign err_ev  = (push && pop) || (push && full) || (pop && empty);
    assign top_idx = cnt_q[PtrW-1:0] - PtrW'(1);

    always_comb begin
        alu_out_d = alu_out_q;
        if (res_we) begin
            alu_out_d = alu_res;
        end
        // A successful pop takes precedence over a same-cycle flags_we.
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = stack_q[top_idx];
        end else if (flags_we) begin
            flags_d = {alu_n, alu_z, alu_c, alu_v};
        end
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - CntW'(1);
        end
        stk_err_d = stk_err_q;
        if (err_ev) begin
            stk_err_d = 1'b1;
        end else if (err_clr) begin
            stk_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            flags_q   <= '0;
            cnt_q     <= '0;
            stk_err_q <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            stk_err_q <= stk_err_d;
        end
    end

    // Stack storage needs no reset; only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            stack_q[cnt_q[PtrW-1:0]] <= flags_q;
        end
    end

    assign {fn, fz, fc, fv} = flags_q;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = fz;
            4'h1: cond_pass = !fz;
            4'h2: cond_pass = fc;
            4'h3: cond_pass = !fc;
            4'h4: cond_pass = fn;
            4'h5: cond_pass = !fn;
            4'h6: cond_pass = fv;
            4'h7: cond_pass = !fv;
            4'h8: cond_pass = fc && !fz;
            4'h9: cond_pass = !fc || fz;
            4'hA: cond_pass = (fn == fv);
            4'hB: cond_pass = (fn != fv);
            4'hC: cond_pass = !fz && (fn == fv);
            4'hD: cond_pass = fz || (fn != fv);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

`ifdef ALU_STATUS_OVF_CNT_EN
    logic [15:0] ovf_q, ovf_d;

    // Counts even when a pop overrides the flag write.
    always_comb begin
        ovf_d = ovf_q;
        if (flags_we && alu_v && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = 16'h0000;
`endif

    assign alu_out   = alu_out_q;
    assign flags     = flags_q;
    assign stk_full  = full;
    assign stk_empty = empty;
    assign stk_err   = stk_err_q;

endmodule

// File: tb/tb_alu_status_unit.sv
// Scoreboard bench for alu_status_unit: directed steps queue expected state, a negedge monitor
// pops and compares. Overflow-count expectations follow ALU_STATUS_OVF_CNT_EN.
module tb_alu_status_unit;

    typedef struct {
        string       nm;
        logic [31:0] out;
        logic [3:0]  flg;
        logic [3:0]  st;   // {full, empty, err, cond_pass}
        logic [15:0] ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] alu_res = '0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic        res_we = 1'b0, flags_we = 1'b0, push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [3:0]  cond = 4'hE;
    logic [31:0] alu_out;
    logic [3:0]  flags;
    logic        cond_pass, stk_full, stk_empty, stk_err;
    logic [15:0] ovf_count;

    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] ovf_model = '0;

    alu_status_unit #(.DATA_W(32), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .alu_res(alu_res), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
        .alu_v(alu_v), .res_we(res_we), .flags_we(flags_we), .push(push), .pop(pop),
        .err_clr(err_clr), .cond(cond), .alu_out(alu_out), .flags(flags),
        .cond_pass(cond_pass), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk(cur.nm, "alu_out", alu_out, cur.out);
            chk(cur.nm, "flags", {28'd0, flags}, {28'd0, cur.flg});
            chk(cur.nm, "stk_full", {31'd0, stk_full}, {31'd0, cur.st[3]});
            chk(cur.nm, "stk_empty", {31'd0, stk_empty}, {31'd0, cur.st[2]});
            chk(cur.nm, "stk_err", {31'd0, stk_err}, {31'd0, cur.st[1]});
            chk(cur.nm, "cond_pass", {31'd0, cond_pass}, {31'd0, cur.st[0]});
            chk(cur.nm, "ovf_count", {16'd0, ovf_count}, {16'd0, cur.ovf});
        end
    end

    task automatic model_ovf(input logic r, input logic fwe, input logic v);
`ifdef ALU_STATUS_OVF_CNT_EN
        if (r) ovf_model = '0;
        else if (fwe && v && ovf_model != 16'hFFFF) ovf_model = ovf_model + 16'd1;
`else
        ovf_model = '0;
`endif
    endtask

    // ops = {rst, res_we, flags_we, push, pop, err_clr}; st = {full, empty, err, cond_pass}
    task automatic step(input string nm, input logic [5:0] ops, input logic [31:0] res,
                        input logic [3:0] nzcv, input logic [3:0] c, input logic [31:0] e_out,
                        input logic [3:0] e_flg, input logic [3:0] e_st);
        exp_t e;
        {rst, res_we, flags_we, push, pop, err_clr} = ops;
        alu_res = res;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        model_ovf(ops[5], ops[3], nzcv[0]);
        @(posedge clk);
        #1;
        {rst, res_we, flags_we, push, pop, err_clr} = '0;
        cond = c;
        e.nm = nm; e.out = e_out; e.flg = e_flg; e.st = e_st; e.ovf = ovf_model;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] H8 = 32'h8000_0000;

    initial begin
        step("reset",     6'b100000, 0,   4'b0000, 4'hE, 0,  4'b0000, 4'b0101);
        step("idle_nv",   6'b000000, 0,   4'b0000, 4'hF, 0,  4'b0000, 4'b0100);
        step("latch_ge",  6'b011000, H8,  4'b1011, 4'hA, H8, 4'b1011, 4'b0101);
        step("hi",        6'b000000, 0,   4'b0000, 4'h8, H8, 4'b1011, 4'b0101);
        step("eq",        6'b000000, 0,   4'b0000, 4'h0, H8, 4'b1011, 4'b0100);
        step("le",        6'b000000, 0,   4'b0000, 4'hD, H8, 4'b1011, 4'b0100);
        step("set_z",     6'b001000, 32'h1234, 4'b0100, 4'h0, H8, 4'b0100, 4'b0101);
        step("push1",     6'b000100, 0,   4'b0000, 4'h1, H8, 4'b0100, 4'b0000);
        step("push2",     6'b000100, 0,   4'b0000, 4'h1, H8, 4'b0100, 4'b0000);
        step("push3",     6'b000100, 0,   4'b0000, 4'h1, H8, 4'b0100, 4'b0000);
        step("push4",     6'b000100, 0,   4'b0000, 4'h1, H8, 4'b0100, 4'b1000);
        step("push_full", 6'b000100, 0,   4'b0000, 4'h1, H8, 4'b0100, 4'b1010);
        step("pop1_ovr",  6'b001010, 0,   4'b0011, 4'h0, H8, 4'b0100, 4'b0011);
        step("pop2",      6'b000010, 0,   4'b0000, 4'h0, H8, 4'b0100, 4'b0011);
        step("pop3",      6'b000010, 0,   4'b0000, 4'h0, H8, 4'b0100, 4'b0011);
        step("pop4",      6'b000010, 0,   4'b0000, 4'h0, H8, 4'b0100, 4'b0111);
        step("pop_empty", 6'b000010, 0,   4'b0000, 4'h0, H8, 4'b0100, 4'b0111);
        step("err_clr",   6'b000001, 0,   4'b0000, 4'h0, H8, 4'b0100, 4'b0101);
        step("save",      6'b001100, 0,   4'b1000, 4'h4, H8, 4'b1000, 4'b0001);
        step("restore",   6'b001010, 0,   4'b0001, 4'h6, H8, 4'b0100, 4'b0100);
        step("clr_vs_err",6'b000011, 0,   4'b0000, 4'hE, H8, 4'b0100, 4'b0111);
        step("clr2",      6'b000001, 0,   4'b0000, 4'hE, H8, 4'b0100, 4'b0101);
        step("f0010",     6'b001000, 0,   4'b0010, 4'h3, H8, 4'b0010, 4'b0100);
        step("pushA",     6'b000100, 0,   4'b0000, 4'h3, H8, 4'b0010, 4'b0000);
        step("f1001_gt",  6'b001000, 0,   4'b1001, 4'hC, H8, 4'b1001, 4'b0001);
        step("pushB",     6'b000100, 0,   4'b0000, 4'hC, H8, 4'b1001, 4'b0001);
        step("pushpop",   6'b001110, 0,   4'b0110, 4'h9, H8, 4'b0110, 4'b0011);
        step("popB",      6'b000010, 0,   4'b0000, 4'hC, H8, 4'b1001, 4'b0011);
        step("popA",      6'b000010, 0,   4'b0000, 4'h3, H8, 4'b0010, 4'b0110);
        step("res_indep", 6'b010100, 32'hDEAD_BEEF, 4'b0000, 4'h2, 32'hDEAD_BEEF, 4'b0010,
             4'b0011);
        step("rst_mid",   6'b111100, 32'h5555_5555, 4'b1111, 4'hE, 0, 4'b0000, 4'b0101);
        step("ovf1",      6'b001000, 0,   4'b0001, 4'h6, 0,  4'b0001, 4'b0101);
        step("ovf2",      6'b001000, 0,   4'b0001, 4'h6, 0,  4'b0001, 4'b0101);
        step("ovf3",      6'b001000, 0,   4'b0001, 4'h6, 0,  4'b0001, 4'b0101);
`ifdef ALU_STATUS_OVF_CNT_EN
        flags_we = 1'b1;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0001;
        for (int i = 0; i < 65535; i++) begin
            model_ovf(1'b0, 1'b1, 1'b1);
            @(posedge clk);
        end
        #1;
        flags_we = 1'b0;
`endif
        step("ovf_sat",   6'b000000, 0,   4'b0000, 4'hF, 0,  4'b0001, 4'b0100);
        step("ovf_rst",   6'b100000, 0,   4'b0001, 4'hE, 0,  4'b0000, 4'b0101);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
